segre_mul_stage: RTL and testbench

- Parametrised, pipelined integer-multiply execution stage for the RV32M MUL/MULH/MULHSU/MULHU group.
- Sits in parallel with the single-cycle EX stage: fed from ID, results merged into MEM/WB.
- Extends the single-cycle EX model in four ways: configurable depth, an N-source operand bypass, independent stall and flush, and per-stage in-flight destination export for the hazard controller.

---
 rtl/segre_mul_stage_pkg.sv | 26 ++
 rtl/segre_mul_stage_if.sv | 45 ++++
 rtl/segre_mul_stage_byp_mux.sv | 21 ++
 rtl/segre_mul_stage.sv | 104 ++++++++++
 tb/tb_segre_mul_stage.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/segre_mul_stage_pkg.sv
// Shared types and defaults for the pipelined RV32M multiply stage.
package segre_mul_stage_pkg;

  typedef enum logic [1:0] {
    MUL_LO  = 2'd0,
    MUL_HSS = 2'd1,
    MUL_HSU = 2'd2,
    MUL_HUU = 2'd3
  } mul_op_e;

  localparam int unsigned MUL_WORD_SIZE = 32;
  localparam int unsigned MUL_REG_SIZE  = 5;
  localparam int unsigned MUL_LATENCY   = 3;
  localparam int unsigned MUL_NUM_BYP   = 2;

  // Operand A is sign-extended for every op except MULHU.
  function automatic logic op_a_signed(input mul_op_e op);
    return op != MUL_HUU;
  endfunction

  // Operand B is sign-extended only for MUL and MULH.
  function automatic logic op_b_signed(input mul_op_e op);
    return (op == MUL_LO) || (op == MUL_HSS);
  endfunction

endpackage

// File: rtl/segre_mul_stage_if.sv
// ID-side request / WB-side result bundle of the multiply stage.
interface segre_mul_stage_if
  import segre_mul_stage_pkg::*;
#(
  parameter int unsigned WORD_SIZE = MUL_WORD_SIZE,
  parameter int unsigned REG_SIZE  = MUL_REG_SIZE,
  parameter int unsigned LATENCY   = MUL_LATENCY,
  parameter int unsigned NUM_BYP   = MUL_NUM_BYP
);
  localparam int unsigned SEL_W = $clog2(NUM_BYP + 1);

  logic                          valid_i;
  logic                          block_i;
  logic                          flush_i;
  mul_op_e                       op_i;
  logic [WORD_SIZE-1:0]          src_a_i;
  logic [WORD_SIZE-1:0]          src_b_i;
  logic [SEL_W-1:0]              byp_sel_a_i;
  logic [SEL_W-1:0]              byp_sel_b_i;
  logic [NUM_BYP*WORD_SIZE-1:0]  byp_data_i;
  logic [REG_SIZE-1:0]           rf_waddr_i;

  logic                          valid_o;
  logic                          rf_we_o;
  logic [REG_SIZE-1:0]           rf_waddr_o;
  logic [WORD_SIZE-1:0]          res_o;
  logic [LATENCY-1:0]            inflight_valid_o;
  logic [LATENCY*REG_SIZE-1:0]   inflight_waddr_o;
  logic                          busy_o;

  modport master (
    output valid_i, block_i, flush_i, op_i, src_a_i, src_b_i,
           byp_sel_a_i, byp_sel_b_i, byp_data_i, rf_waddr_i,
    input  valid_o, rf_we_o, rf_waddr_o, res_o,
           inflight_valid_o, inflight_waddr_o, busy_o
  );

  modport slave (
    input  valid_i, block_i, flush_i, op_i, src_a_i, src_b_i,
           byp_sel_a_i, byp_sel_b_i, byp_data_i, rf_waddr_i,
    output valid_o, rf_we_o, rf_waddr_o, res_o,
           inflight_valid_o, inflight_waddr_o, busy_o
  );

endinterface

// File: rtl/segre_mul_stage_byp_mux.sv
// Operand bypass selector: 0 or any out-of-range select picks the register-file value.
module segre_byp_mux #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 2,
  localparam int unsigned SEL_W  = $clog2(NUM_SRC + 1)
) (
  input  logic [WIDTH-1:0]         i_src,
  input  logic [NUM_SRC*WIDTH-1:0] i_byp,
  input  logic [SEL_W-1:0]         i_sel,
  output logic [WIDTH-1:0]         o_data_c
);

  // Pick bypass slice k-1 when the select equals k, else fall back to the source.
  always_comb begin
    o_data_c = i_src;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      if (i_sel == SEL_W'(k)) o_data_c = i_byp[(k-1)*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/segre_mul_stage.sv
// Pipelined RV32M multiply stage with bypass, block/flush and in-flight export.
// Stage data fields are kept at zero whenever a stage is empty, so the
// outputs can be driven straight from the last stage register.
module segre_mul_stage
  import segre_mul_stage_pkg::*;
#(
  parameter int unsigned WORD_SIZE = MUL_WORD_SIZE,
  parameter int unsigned REG_SIZE  = MUL_REG_SIZE,
  parameter int unsigned LATENCY   = MUL_LATENCY,
  parameter int unsigned NUM_BYP   = MUL_NUM_BYP
) (
  input  logic            clk_i,
  input  logic            rst_i,
  segre_mul_stage_if.slave bus
);
  localparam int unsigned PROD_W = 2 * WORD_SIZE;

  logic [WORD_SIZE-1:0]                w_opa;
  logic [WORD_SIZE-1:0]                w_opb;
  logic signed [WORD_SIZE:0]           w_a_ext;
  logic signed [WORD_SIZE:0]           w_b_ext;
  logic signed [PROD_W-1:0]            w_prod;
  logic [WORD_SIZE-1:0]                w_res;

  logic [LATENCY-1:0]                  r_valid, w_valid_nxt;
  logic [LATENCY-1:0]                  r_we, w_we_nxt;
  logic [LATENCY-1:0][REG_SIZE-1:0]    r_waddr, w_waddr_nxt;
  logic [LATENCY-1:0][WORD_SIZE-1:0]   r_res, w_res_nxt;
  logic                                r_busy;

  segre_byp_mux #(.WIDTH(WORD_SIZE), .NUM_SRC(NUM_BYP)) u_byp_a (
    .i_src    (bus.src_a_i),
    .i_byp    (bus.byp_data_i),
    .i_sel    (bus.byp_sel_a_i),
    .o_data_c (w_opa)
  );

  segre_byp_mux #(.WIDTH(WORD_SIZE), .NUM_SRC(NUM_BYP)) u_byp_b (
    .i_src    (bus.src_b_i),
    .i_byp    (bus.byp_data_i),
    .i_sel    (bus.byp_sel_b_i),
    .o_data_c (w_opb)
  );

  // Extended-operand multiply; the product is truncated to 2*WORD_SIZE bits.
  always_comb begin
    w_a_ext = $signed({op_a_signed(bus.op_i) & w_opa[WORD_SIZE-1], w_opa});
    w_b_ext = $signed({op_b_signed(bus.op_i) & w_opb[WORD_SIZE-1], w_opb});
    w_prod  = PROD_W'(w_a_ext) * PROD_W'(w_b_ext);
    w_res   = (bus.op_i == MUL_LO) ? w_prod[WORD_SIZE-1:0]
                                   : w_prod[PROD_W-1:WORD_SIZE];
  end

  // Next stage contents: flush clears, block holds, otherwise shift and accept.
  always_comb begin
    w_valid_nxt = r_valid;
    w_we_nxt    = r_we;
    w_waddr_nxt = r_waddr;
    w_res_nxt   = r_res;
    if (bus.flush_i) begin
      w_valid_nxt = '0;
      w_we_nxt    = '0;
      w_waddr_nxt = '0;
      w_res_nxt   = '0;
    end else if (!bus.block_i) begin
      for (int unsigned i = 1; i < LATENCY; i++) begin
        w_valid_nxt[i] = r_valid[i-1];
        w_we_nxt[i]    = r_we[i-1];
        w_waddr_nxt[i] = r_waddr[i-1];
        w_res_nxt[i]   = r_res[i-1];
      end
      w_valid_nxt[0] = bus.valid_i;
      w_we_nxt[0]    = bus.valid_i && (bus.rf_waddr_i != '0);
      w_waddr_nxt[0] = bus.valid_i ? bus.rf_waddr_i : '0;
      w_res_nxt[0]   = bus.valid_i ? w_res : '0;
    end
  end

  // Stage registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_we    <= '0;
      r_waddr <= '0;
      r_res   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= w_valid_nxt;
      r_we    <= w_we_nxt;
      r_waddr <= w_waddr_nxt;
      r_res   <= w_res_nxt;
      r_busy  <= |w_valid_nxt;
    end
  end

  assign bus.valid_o          = r_valid[LATENCY-1];
  assign bus.rf_we_o          = r_we[LATENCY-1];
  assign bus.rf_waddr_o       = r_waddr[LATENCY-1];
  assign bus.res_o            = r_res[LATENCY-1];
  assign bus.inflight_valid_o = r_valid;
  assign bus.inflight_waddr_o = r_waddr;
  assign bus.busy_o           = r_busy;

endmodule

// File: tb/tb_segre_mul_stage.sv
// Self-checking bench for segre_mul_stage: directed cases plus random traffic
// compared against an age-tagged queue model of in-flight multiplies.
module tb_segre_mul_stage;
  import segre_mul_stage_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned R  = 5;
  localparam int unsigned L  = 3;
  localparam int unsigned NB = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  segre_mul_stage_if #(.WORD_SIZE(W), .REG_SIZE(R), .LATENCY(L), .NUM_BYP(NB)) bus ();

  segre_mul_stage #(.WORD_SIZE(W), .REG_SIZE(R), .LATENCY(L), .NUM_BYP(NB)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  waddr;
    int          age;
  } op_t;

  op_t pipe_q[$];
  int  err_cnt = 0;
  int  chk_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // True RV32M result from 64-bit arithmetic on sign/zero-extended operands.
  function automatic logic [31:0] ref_mul(input mul_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == MUL_HUU) ? {32'b0, a} : {{32{a[31]}}, a};
    eb = (op == MUL_LO || op == MUL_HSS) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == MUL_LO) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] src, input logic [63:0] byp);
    if (sel == 2'd1) return byp[31:0];
    if (sel == 2'd2) return byp[63:32];
    return src;
  endfunction

  task automatic check_outputs(input string tag);
    logic        exp_v;
    logic [31:0] exp_res;
    logic [4:0]  exp_wa;
    logic [2:0]  exp_if;
    logic [4:0]  wa_at [3];
    exp_v = 1'b0; exp_res = '0; exp_wa = '0; exp_if = '0;
    for (int k = 0; k < 3; k++) wa_at[k] = '0;
    foreach (pipe_q[i]) begin
      exp_if[pipe_q[i].age] = 1'b1;
      wa_at[pipe_q[i].age]  = pipe_q[i].waddr;
      if (pipe_q[i].age == int'(L) - 1) begin
        exp_v = 1'b1; exp_res = pipe_q[i].res; exp_wa = pipe_q[i].waddr;
      end
    end
    check_eq({tag, ".valid_o"}, 64'(bus.valid_o), 64'(exp_v));
    check_eq({tag, ".res_o"}, 64'(bus.res_o), 64'(exp_res));
    check_eq({tag, ".rf_we_o"}, 64'(bus.rf_we_o), 64'(exp_v && exp_wa != 5'd0));
    if (exp_v) check_eq({tag, ".rf_waddr_o"}, 64'(bus.rf_waddr_o), 64'(exp_wa));
    check_eq({tag, ".busy_o"}, 64'(bus.busy_o), 64'(pipe_q.size() != 0));
    check_eq({tag, ".inflight_valid_o"}, 64'(bus.inflight_valid_o), 64'(exp_if));
    for (int k = 0; k < 3; k++)
      if (exp_if[k]) check_eq({tag, ".inflight_waddr_o"}, 64'(bus.inflight_waddr_o[k*R +: R]), 64'(wa_at[k]));
  endtask

  // One clock: drive inputs, advance the model at the edge, check at the falling edge.
  task automatic cycle(input string tag, input logic v, input logic blk, input logic fl,
                       input mul_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] sa, input logic [1:0] sb,
                       input logic [63:0] byp, input logic [4:0] wa);
    bus.valid_i = v;   bus.block_i = blk; bus.flush_i = fl; bus.op_i = op;
    bus.src_a_i = a;   bus.src_b_i = b;   bus.byp_sel_a_i = sa; bus.byp_sel_b_i = sb;
    bus.byp_data_i = byp; bus.rf_waddr_i = wa;
    @(posedge clk);
    if (fl) pipe_q.delete();
    else if (!blk) begin
      foreach (pipe_q[i]) pipe_q[i].age++;
      while (pipe_q.size() > 0 && pipe_q[0].age >= int'(L)) void'(pipe_q.pop_front());
      if (v) pipe_q.push_back('{ref_mul(op, pick(sa, a, byp), pick(sb, b, byp)), wa, 0});
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b0, 1'b0, MUL_LO, 32'd0, 32'd0, 2'd0, 2'd0, 64'd0, 5'd0);
  endtask

  task automatic issue(input string tag, input mul_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wa);
    cycle(tag, 1'b1, 1'b0, 1'b0, op, a, b, 2'd0, 2'd0, 64'd0, wa);
  endtask

  // Reset pulse placed between edges; outputs must clear without a clock.
  task automatic reset_pulse(input string tag);
    #2 rst = 1'b1;
    #1;
    check_eq({tag, ".valid_o"}, 64'(bus.valid_o), 64'd0);
    check_eq({tag, ".res_o"}, 64'(bus.res_o), 64'd0);
    check_eq({tag, ".busy_o"}, 64'(bus.busy_o), 64'd0);
    check_eq({tag, ".inflight_valid_o"}, 64'(bus.inflight_valid_o), 64'd0);
    pipe_q.delete();
    #1 rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    bus.valid_i = 1'b0; bus.block_i = 1'b0; bus.flush_i = 1'b0; bus.op_i = MUL_LO;
    bus.src_a_i = '0; bus.src_b_i = '0; bus.byp_sel_a_i = '0; bus.byp_sel_b_i = '0;
    bus.byp_data_i = '0; bus.rf_waddr_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset.valid_o", 64'(bus.valid_o), 64'd0);
    check_eq("reset.rf_we_o", 64'(bus.rf_we_o), 64'd0);
    check_eq("reset.res_o", 64'(bus.res_o), 64'd0);
    check_eq("reset.rf_waddr_o", 64'(bus.rf_waddr_o), 64'd0);
    check_eq("reset.busy_o", 64'(bus.busy_o), 64'd0);
    check_eq("reset.inflight_valid_o", 64'(bus.inflight_valid_o), 64'd0);
    check_eq("reset.inflight_waddr_o", 64'(bus.inflight_waddr_o), 64'd0);
    rst = 1'b0;

    // Latency and single-cycle result of MUL.
    issue("lat", MUL_LO, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5);
    idle("lat"); idle("lat");
    check_eq("lat.res_const", 64'(bus.res_o), 64'hFFFF_FFEB);
    check_eq("lat.we_const", 64'(bus.rf_we_o), 64'd1);
    check_eq("lat.waddr_const", 64'(bus.rf_waddr_o), 64'd5);
    idle("lat");
    check_eq("lat.one_cycle", 64'(bus.valid_o), 64'd0);

    // High-word variants back to back.
    issue("hi", MUL_HSS, 32'h8000_0000, 32'h8000_0000, 5'd1);
    issue("hi", MUL_HUU, 32'h8000_0000, 32'h8000_0000, 5'd2);
    issue("hi", MUL_HSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    check_eq("hi.mulh_const", 64'(bus.res_o), 64'h4000_0000);
    idle("hi");
    check_eq("hi.mulhu_const", 64'(bus.res_o), 64'h4000_0000);
    idle("hi");
    check_eq("hi.mulhsu_const", 64'(bus.res_o), 64'hFFFF_FFFF);
    idle("hi");

    // Bypass: slice 1 on A, out-of-range select on B.
    cycle("byp", 1'b1, 1'b0, 1'b0, MUL_LO, 32'h1234_5678, 32'h3, 2'd2, 2'd3,
          {32'h0000_0010, 32'hDEAD_BEEF}, 5'd7);
    idle("byp"); idle("byp");
    check_eq("byp.res_const", 64'(bus.res_o), 64'h30);
    idle("byp");

    // Back-to-back accepts with a 2-cycle block while op1 is on the output.
    issue("blk", MUL_LO, 32'd11, 32'd3, 5'd11);
    issue("blk", MUL_LO, 32'd12, 32'd3, 5'd12);
    issue("blk", MUL_LO, 32'd13, 32'd3, 5'd13);
    for (int i = 0; i < 2; i++) begin
      cycle("blk.hold", 1'b1, 1'b1, 1'b0, MUL_LO, 32'd14, 32'd3, 2'd0, 2'd0, 64'd0, 5'd14);
      check_eq("blk.res_held", 64'(bus.res_o), 64'd33);
      check_eq("blk.inflight_111", 64'(bus.inflight_valid_o), 64'h7);
    end
    issue("blk", MUL_LO, 32'd14, 32'd3, 5'd14);
    check_eq("blk.op2_next", 64'(bus.res_o), 64'd36);
    repeat (4) idle("blk");

    // Flush wins over block and drops the same-cycle op.
    issue("fl", MUL_HUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    issue("fl", MUL_LO, 32'd5, 32'd5, 5'd10);
    cycle("fl.kill", 1'b1, 1'b1, 1'b1, MUL_LO, 32'd6, 32'd6, 2'd0, 2'd0, 64'd0, 5'd8);
    check_eq("fl.busy_const", 64'(bus.busy_o), 64'd0);
    repeat (4) idle("fl");

    // Asynchronous reset with three live ops, then an x0 destination.
    issue("rst", MUL_LO, 32'd2, 32'd3, 5'd4);
    issue("rst", MUL_LO, 32'd4, 32'd5, 5'd6);
    issue("rst", MUL_LO, 32'd6, 32'd7, 5'd8);
    reset_pulse("rst.async");
    repeat (4) idle("rst.after");
    issue("x0", MUL_LO, 32'd9, 32'd9, 5'd0);
    idle("x0"); idle("x0");
    check_eq("x0.valid_const", 64'(bus.valid_o), 64'd1);
    check_eq("x0.we_const", 64'(bus.rf_we_o), 64'd0);
    idle("x0");

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic v, blk, fl;
      v   = ($urandom_range(0, 9) < 7);
      blk = ($urandom_range(0, 9) < 2);
      fl  = ($urandom_range(0, 29) == 0);
      cycle("rnd", v, blk, fl, mul_op_e'($urandom_range(0, 3)), rand_word(), rand_word(),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            {rand_word(), rand_word()}, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 49) == 0) reset_pulse("rnd.rst");
    end
    repeat (4) idle("drain");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
